table_entry_fetcher: RTL and testbench
======================================

// Module: table_entry_fetcher
// PURPOSE
//  Writer side of the object buffer's new_entry/valid_in/full interface.
//  On start, walks a flattened descriptor table in memory and issues pipelined
//  row reads. It pushes the returned TABLE_ENTRY rows, in order, into the
//  object buffer. Nested sub-message rows are inline, and each sub-message is
//  closed by a field_id==0 terminator. Fetch ends after the terminator that
//  closes the top-level message (depth 0).
// PARAMETERS
//  FIFO_DEPTH   4   response skid FIFO entries; also the max reads in flight + queued
//  ENTRY_BYTES  16  address stride between table rows
//  MAX_DEPTH    15  max nesting depth (object buffer pointer stack has 16 rows)
// PORTS
//  clk             in   1           clock
//  reset           in   1           reset, synchronous, active-high
//  start           in   1           pulse: begin fetch at table_base_addr (ignored unless IDLE)
//  table_base_addr in   64          byte address of the first row, sampled on start
//  busy            out  1           high from the cycle after start until done
//  done            out  1           1-cycle pulse when the walk is complete and drained
//  error           out  1           sticky: nesting exceeded MAX_DEPTH; cleared on start
//  mem_req_valid   out  1           read request valid
//  mem_req_ready   in   1           memory accepts the request (valid&ready = issued)
//  mem_req_addr    out  64          row address
//  mem_rsp_valid   in   1           in-order read response valid (no backpressure)
//  mem_rsp_entry   in   TABLE_ENTRY returned row
//  ob_full         in   1           object buffer full (registered in the object buffer)
//  ob_valid        out  1           drives object buffer valid_in
//  ob_entry        out  TABLE_ENTRY drives object buffer new_entry
//  entries_sent    out  16          rows pushed since the last start (wraps)
// BEHAVIOUR
//  Reset values: busy=0, done=0, error=0, mem_req_valid=0, ob_valid=0,
//   entries_sent=0. The FIFO, depth, outstanding and addr counters clear. State=IDLE.
//  States and transitions:
//   IDLE -> FETCH on start.
//    Latch addr=table_base_addr. Clear depth, outstanding, FIFO, entries_sent, error.
//   FETCH -> DRAIN when the end condition is hit at push time.
//   DRAIN -> IDLE when outstanding==0. done pulses in that same cycle.
//  Issue (FETCH only):
//   mem_req_valid = (outstanding + fifo_count) < FIFO_DEPTH.
//   On handshake: addr += ENTRY_BYTES and outstanding += 1.
//   mem_req_addr holds its value while valid and !ready.
//  Response: each mem_rsp_valid decrements outstanding.
//   FETCH: the row is written to the FIFO. The credit rule guarantees no overflow.
//   IDLE or DRAIN: the row is discarded.
//  Push (FETCH only):
//   ob_valid = fifo_count!=0 && !ob_full. ob_entry = FIFO head.
//   Pop on ob_valid. At most 1 push per cycle; ob_full is honoured every cycle.
//  Depth tracking on each pushed row:
//   nested=1:                    depth+1.
//   field_id==0 and depth>0:     depth-1.
//   field_id==0 and depth==0:    the walk ends; go DRAIN and flush the FIFO.
//  Error path: a nested row arriving with depth==MAX_DEPTH is not pushed.
//   error=1 and the FSM goes DRAIN with the FIFO flushed.
//  entries_sent += 1 per push, 16-bit wrap. An empty FIFO pushes nothing.
//  Simultaneous response + pop in one cycle: fifo_count is unchanged.
//  Simultaneous issue + response in one cycle: outstanding is unchanged.
//  Rows fetched speculatively past the final terminator are never pushed.
//  Reset mid-fetch returns to IDLE next cycle. Late responses are then dropped.
//  Latency: first request in the cycle after start.
//   First push the cycle after the first response, if !ob_full.
// TESTING
//  1. Flat table: base 0x1000, rows f1,f2,f3,term, mem ready always, 1-cycle rsp.
//     -> reqs 0x1000,0x1010,...; 4 pushes in order; entries_sent=4; done, error=0.
//  2. Nested table: f1,n2(nested),f3,term,f4,term.
//     -> all 6 rows pushed; done only after the second terminator; depth returns to 0.
//  3. Backpressure: hold ob_full=1 for 10 cycles mid-walk.
//     -> no push while full; at most FIFO_DEPTH reads outstanding+queued;
//        order is preserved; no row is lost or duplicated.
//  4. Speculative overfetch: term at row 1, FIFO_DEPTH=4.
//     -> rows 2..3 fetched but not pushed; done after all responses; entries_sent=2.
//  5. Depth overflow: 16 consecutive nested rows.
//     -> 15 pushed; 16th dropped; error=1; done pulses; next start clears error.
//  6. Reset during FETCH with 3 reads in flight.
//     -> IDLE next cycle, all outputs at reset values; late responses ignored;
//        a new start works normally.

Source files
------------

// File: rtl/table_entry_fetcher.sv
// Walks a flattened descriptor table with pipelined row reads and streams the rows, in order,
// into the object buffer, stopping after the terminator that closes the top-level message.

typedef struct packed {
  logic [15:0] field_id;
  logic        nested;
  logic [6:0]  wire_type;
  logic [7:0]  sub_index;
  logic [31:0] offset;
} table_entry_t;

module table_entry_fetcher #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ENTRY_BYTES = 16,
  parameter int MAX_DEPTH   = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  table_base_addr,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [63:0]  mem_req_addr,
  input  logic         mem_rsp_valid,
  input  table_entry_t mem_rsp_entry,
  input  logic         ob_full,
  output logic         ob_valid,
  output table_entry_t ob_entry,
  output logic [15:0]  entries_sent
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_SLOT    = PW'(FIFO_DEPTH - 1);
  localparam logic [DW-1:0] DEPTH_LIMIT  = DW'(MAX_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state;
  logic [63:0]   addr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [DW-1:0] depth;
  table_entry_t  fifo_mem [FIFO_DEPTH];

  logic          issue;
  logic          rsp_accept;
  logic          rsp_retire;
  logic          head_valid;
  logic          head_overflow;
  logic          head_is_term;
  logic [CW:0]   credit_used;
  table_entry_t  head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Reads in flight plus rows already queued may never exceed the FIFO, so responses never overflow it.
  assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign mem_req_valid = (state == FETCH) && (credit_used < CREDIT_LIMIT);
  assign mem_req_addr  = addr;
  assign issue         = mem_req_valid && mem_req_ready;
  assign rsp_accept    = mem_rsp_valid && (state == FETCH);
  assign rsp_retire    = mem_rsp_valid && (outstanding != '0);

  assign head          = fifo_mem[rd_ptr];
  assign head_valid    = (state == FETCH) && (fifo_count != '0);
  assign head_overflow = head_valid && head.nested && (depth == DEPTH_LIMIT);
  assign head_is_term  = !head.nested && (head.field_id == 16'd0);
  assign ob_valid      = head_valid && !ob_full && !head_overflow;
  assign ob_entry      = head;

  assign busy = (state != IDLE);
  assign done = (state == DRAIN) && (outstanding == '0);

  always_ff @(posedge clk) begin
    if (rsp_accept) fifo_mem[wr_ptr] <= mem_rsp_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      outstanding  <= '0;
      fifo_count   <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      depth        <= '0;
      error        <= 1'b0;
      entries_sent <= '0;
    end else begin
      case ({issue, rsp_retire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      if (issue) addr <= addr + 64'(ENTRY_BYTES);

      case ({rsp_accept, ob_valid})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (rsp_accept) wr_ptr <= ptr_inc(wr_ptr);

      if (ob_valid) begin
        rd_ptr       <= ptr_inc(rd_ptr);
        entries_sent <= entries_sent + 16'd1;
        if (head.nested) depth <= depth + 1'b1;
        else if (head_is_term && depth != '0) depth <= depth - 1'b1;
      end

      // State handling comes last so that start and the end-of-walk flush win over the updates above.
      case (state)
        IDLE: begin
          if (start) begin
            state        <= FETCH;
            addr         <= table_base_addr;
            outstanding  <= '0;
            fifo_count   <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            depth        <= '0;
            error        <= 1'b0;
            entries_sent <= '0;
          end
        end
        FETCH: begin
          if (head_overflow || (ob_valid && head_is_term && depth == '0)) begin
            state      <= DRAIN;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            if (head_overflow) error <= 1'b1;
          end
        end
        DRAIN: begin
          if (outstanding == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_table_entry_fetcher.sv
// Scoreboard bench for table_entry_fetcher: a memory model answers row reads, a monitor checks
// every request address and every pushed row against queues filled when each walk is started.

module tb_table_entry_fetcher;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] table_base_addr;
  logic        busy, done, error;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_entry;
  logic        ob_full;
  logic        ob_valid;
  logic [63:0] ob_entry;
  logic [15:0] entries_sent;

  table_entry_fetcher #(.FIFO_DEPTH(FIFO_DEPTH), .ENTRY_BYTES(16), .MAX_DEPTH(15)) dut (
    .clk(clk), .reset(reset), .start(start), .table_base_addr(table_base_addr),
    .busy(busy), .done(done), .error(error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_entry(mem_rsp_entry),
    .ob_full(ob_full), .ob_valid(ob_valid), .ob_entry(ob_entry), .entries_sent(entries_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  int          tests = 0;
  int          failures = 0;
  logic [63:0] mem_rows [64];
  logic [63:0] mem_base = '0;
  int          lat = 1;
  bit          rdy_alt = 1'b0;
  pend_t       pend[$];
  int          cyc = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_addr = '0;
  int          issued = 0;
  int          pushes = 0;
  logic [63:0] rows[$];

  function automatic logic [63:0] mk(input logic [15:0] fid, input logic nested, input logic [31:0] off);
    return {fid, nested, 7'd2, 8'd0, off};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Fills memory with the table and queues the rows the walk is expected to push.
  task automatic loadTable(input int n_push);
    for (int i = 0; i < 64; i++) mem_rows[i] = (i < rows.size()) ? rows[i] : 64'd0;
    exp_q.delete();
    for (int i = 0; i < n_push; i++) exp_q.push_back(rows[i]);
  endtask

  task automatic applyStimulus(input logic [63:0] base);
    @(posedge clk); #1;
    mem_base        = base;
    exp_addr        = base;
    issued          = 0;
    pushes          = 0;
    table_base_addr = base;
    start           = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit, input logic [15:0] exp_sent, input logic exp_err);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      checkOutput("rsp_drained", 64'(pend.size()), 64'd0);
      checkOutput("entries_sent", 64'(entries_sent), 64'(exp_sent));
      checkOutput("error", 64'(error), 64'(exp_err));
      checkOutput("all_rows_pushed", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      checkOutput("busy_after_done", 64'(busy), 64'd0);
      checkOutput("done_pulse", 64'(done), 64'd0);
    end
  endtask

  // Memory: accepts a request at the clock edge and returns its row lat cycles later, in order.
  initial begin
    bit          hs;
    logic [63:0] hs_addr;
    logic [63:0] off;
    pend_t       p;
    mem_rsp_valid = 1'b0;
    mem_rsp_entry = '0;
    mem_req_ready = 1'b1;
    forever begin
      @(negedge clk);
      hs      = mem_req_valid && mem_req_ready;
      hs_addr = mem_req_addr;
      @(posedge clk);
      cyc++;
      #1;
      if (hs) pend.push_back('{hs_addr, cyc + lat - 1});
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        p             = pend.pop_front();
        off           = p.addr - mem_base;
        mem_rsp_valid = 1'b1;
        mem_rsp_entry = mem_rows[off[9:4]];
      end else begin
        mem_rsp_valid = 1'b0;
      end
      mem_req_ready = rdy_alt ? ~mem_req_ready : 1'b1;
    end
  end

  // Monitor: request addresses, credit limit, address hold, backpressure and pushed-row order.
  initial begin
    bit          hold_chk = 1'b0;
    logic [63:0] hold_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_chk = 1'b0;
        continue;
      end
      if (hold_chk && mem_req_valid) checkOutput("addr_hold", mem_req_addr, hold_addr);
      hold_chk  = mem_req_valid && !mem_req_ready;
      hold_addr = mem_req_addr;
      if (mem_req_valid && mem_req_ready) begin
        checkOutput("req_addr", mem_req_addr, exp_addr);
        exp_addr = exp_addr + 64'd16;
        issued++;
        checkOutput("credit_limit", 64'(issued - pushes <= FIFO_DEPTH), 64'd1);
      end
      if (ob_full && busy) checkOutput("no_push_when_full", 64'(ob_valid), 64'd0);
      if (ob_valid) begin
        if (exp_q.size() == 0) checkOutput("unexpected_push", ob_entry, 64'd0 - 64'd1);
        else checkOutput($sformatf("push_row%0d", pushes), ob_entry, exp_q.pop_front());
        pushes++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; table_base_addr = '0; ob_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_error", 64'(error), 64'd0);
    checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_ob_valid", 64'(ob_valid), 64'd0);
    checkOutput("rst_entries", 64'(entries_sent), 64'd0);

    $display("[TB] flat table");
    rows.delete();
    rows.push_back(mk(16'd1, 1'b0, 32'h0)); rows.push_back(mk(16'd2, 1'b0, 32'h4));
    rows.push_back(mk(16'd3, 1'b0, 32'h8)); rows.push_back(mk(16'd0, 1'b0, 32'h0));
    loadTable(4);
    applyStimulus(64'h1000);
    waitDone(100, 16'd4, 1'b0);

    $display("[TB] nested table");
    rows.delete();
    rows.push_back(mk(16'd1, 1'b0, 32'h0)); rows.push_back(mk(16'd2, 1'b1, 32'h8));
    rows.push_back(mk(16'd3, 1'b0, 32'h0)); rows.push_back(mk(16'd0, 1'b0, 32'h0));
    rows.push_back(mk(16'd4, 1'b0, 32'h10)); rows.push_back(mk(16'd0, 1'b0, 32'h0));
    loadTable(6);
    applyStimulus(64'h2000);
    waitDone(100, 16'd6, 1'b0);

    $display("[TB] backpressure");
    rows.delete();
    for (int i = 0; i < 9; i++) rows.push_back(mk(16'(i + 10), 1'b0, 32'(i * 4)));
    rows.push_back(mk(16'd0, 1'b0, 32'h0));
    loadTable(10);
    rdy_alt = 1'b1;
    applyStimulus(64'h3000);
    repeat (3) @(posedge clk);
    #1 ob_full = 1'b1;
    repeat (10) @(posedge clk);
    #1 ob_full = 1'b0;
    waitDone(200, 16'd10, 1'b0);
    rdy_alt = 1'b0;

    $display("[TB] speculative overfetch");
    repeat (2) @(posedge clk);
    rows.delete();
    rows.push_back(mk(16'd5, 1'b0, 32'h0)); rows.push_back(mk(16'd0, 1'b0, 32'h0));
    rows.push_back(mk(16'd6, 1'b0, 32'h4)); rows.push_back(mk(16'd7, 1'b0, 32'h8));
    loadTable(2);
    applyStimulus(64'h4000);
    waitDone(100, 16'd2, 1'b0);
    checkOutput("overfetch_reads", 64'(issued), 64'd4);

    $display("[TB] depth overflow");
    rows.delete();
    for (int i = 0; i < 16; i++) rows.push_back(mk(16'(i + 1), 1'b1, 32'(i)));
    loadTable(15);
    applyStimulus(64'h5000);
    waitDone(200, 16'd15, 1'b1);

    $display("[TB] reset during fetch");
    rows.delete();
    for (int i = 0; i < 8; i++) rows.push_back(mk(16'(i + 20), 1'b0, 32'(i)));
    rows.push_back(mk(16'd0, 1'b0, 32'h0));
    loadTable(9);
    lat = 6;
    applyStimulus(64'h6000);
    @(negedge clk);
    checkOutput("error_cleared_on_start", 64'(error), 64'd0);
    n = 0;
    while (issued < 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("reads_in_flight", 64'(issued >= 2), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("midrst_ob_valid", 64'(ob_valid), 64'd0);
    checkOutput("midrst_entries", 64'(entries_sent), 64'd0);
    repeat (12) @(posedge clk);
    checkOutput("late_rsps_returned", 64'(pend.size()), 64'd0);
    checkOutput("late_rsps_no_push", 64'(entries_sent), 64'd0);
    lat = 1;

    rows.delete();
    rows.push_back(mk(16'd30, 1'b0, 32'h0)); rows.push_back(mk(16'd31, 1'b1, 32'h4));
    rows.push_back(mk(16'd0, 1'b0, 32'h0)); rows.push_back(mk(16'd0, 1'b0, 32'h0));
    loadTable(4);
    applyStimulus(64'h7000);
    waitDone(100, 16'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
